fifo_sync_prog: RTL and testbench

FIFO_SYNC_PROG -- requirements
Module: fifo_sync_prog

---
 rtl/fifo_sync_prog.sv | 69 ++++++
 tb/tb_fifo_sync_prog.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock FIFO with programmable thresholds, sticky errors and optional FWFT read
//   clk, rst (async, active-high)
//   wr_en/data_in write port, rd_en/data_out read port
//   af_thresh/ae_thresh live almost-full/almost-empty thresholds
//   full, empty, half, almost_full, almost_empty, count status from registered occupancy
//   overflow/underflow sticky errors, cleared by clr_err
module fifo_sync_prog #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  half,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);
  localparam logic [ADDR_WIDTH:0] DEPTH_C = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] HALF_C  = {2'b01, {(ADDR_WIDTH-1){1'b0}}};
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wp, rp;
  logic                  wr_ok, rd_ok;
  always_comb begin
    full         = count == DEPTH_C;
    empty        = count == '0;
    half         = count >= HALF_C;
    almost_full  = count >= af_thresh;
    almost_empty = count <= ae_thresh;
    wr_ok        = wr_en & ~full;
    rd_ok        = rd_en & ~empty;
  end
  always_ff @(posedge clk)
    if (wr_ok) mem[wp] <= data_in;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp        <= '0;
      rp        <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wp        <= wr_ok ? wp + 1'b1 : wp;
      rp        <= rd_ok ? rp + 1'b1 : rp;
      count     <= (wr_ok & ~rd_ok) ? count + 1'b1 : (rd_ok & ~wr_ok) ? count - 1'b1 : count;
      overflow  <= (wr_en & full) | (overflow & ~clr_err);
      underflow <= (rd_en & empty) | (underflow & ~clr_err);
    end
  if (FWFT != 0) begin : g_fwft
    assign data_out = empty ? '0 : mem[rp];
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout;
    always_ff @(posedge clk or posedge rst)
      if (rst) dout <= '0;
      else if (rd_ok) dout <= mem[rp];
    assign data_out = dout;
  end
endmodule

// File: tb/tb_fifo_sync_prog.sv
// tb_fifo_sync_prog: checks standard and FWFT instances against a queue model plus directed vectors
module tb_fifo_sync_prog;
  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] data_in = '0;
  logic [6:0] af_thresh = 7'd0, ae_thresh = 7'd4;
  logic [1:0] full, empty, half, af, ae, ov, uf;
  logic [6:0] cnt [2];
  logic [7:0] dout [2];
  int tests = 0, fails = 0;
  logic [7:0] q [$];
  logic [7:0] dout0_m = '0;
  logic       ov_m = 1'b0, uf_m = 1'b0;
  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic [6:0] cnt;
    logic       emp;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       uf;
  } vec_t;
  vec_t tbl [8];
  always #5 clk = ~clk;
  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .data_out(dout[0]),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err), .full(full[0]), .empty(empty[0]),
    .half(half[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(cnt[0]), .overflow(ov[0]),
    .underflow(uf[0]));
  fifo_sync_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(6), .FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en), .data_out(dout[1]),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .clr_err(clr_err), .full(full[1]), .empty(empty[1]),
    .half(half[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(cnt[1]), .overflow(ov[1]),
    .underflow(uf[1]));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  task automatic check_all();
    int sz = q.size();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("count%0d", i), 32'(cnt[i]), 32'(sz));
      chk($sformatf("full%0d", i), 32'(full[i]), 32'(sz == 64));
      chk($sformatf("empty%0d", i), 32'(empty[i]), 32'(sz == 0));
      chk($sformatf("half%0d", i), 32'(half[i]), 32'(sz >= 32));
      chk($sformatf("almost_full%0d", i), 32'(af[i]), 32'(sz >= int'(af_thresh)));
      chk($sformatf("almost_empty%0d", i), 32'(ae[i]), 32'(sz <= int'(ae_thresh)));
      chk($sformatf("overflow%0d", i), 32'(ov[i]), 32'(ov_m));
      chk($sformatf("underflow%0d", i), 32'(uf[i]), 32'(uf_m));
    end
    chk("dout_std", 32'(dout[0]), 32'(dout0_m));
    chk("dout_fwft", 32'(dout[1]), sz > 0 ? 32'(q[0]) : 32'd0);
  endtask
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    int sz;
    wr_en = w; data_in = d; rd_en = r; clr_err = c;
    @(posedge clk);
    sz = q.size();
    ov_m = (w && sz == 64) || (ov_m && !c);
    uf_m = (r && sz == 0) || (uf_m && !c);
    if (r && sz > 0) dout0_m = q.pop_front();
    if (w && sz < 64) q.push_back(d);
    #1;
    check_all();
  endtask
  task automatic model_reset();
    q.delete();
    dout0_m = '0; ov_m = 1'b0; uf_m = 1'b0;
  endtask
  initial begin
    tbl[0] = '{1, 8'hA5, 0, 0, 7'd1, 0, 8'h00, 8'hA5, 0};
    tbl[1] = '{1, 8'h3C, 0, 0, 7'd2, 0, 8'h00, 8'hA5, 0};
    tbl[2] = '{0, 8'h00, 1, 0, 7'd1, 0, 8'hA5, 8'h3C, 0};
    tbl[3] = '{1, 8'h11, 1, 0, 7'd1, 0, 8'h3C, 8'h11, 0};
    tbl[4] = '{0, 8'h00, 1, 0, 7'd0, 1, 8'h11, 8'h00, 0};
    tbl[5] = '{0, 8'h00, 1, 0, 7'd0, 1, 8'h11, 8'h00, 1};
    tbl[6] = '{0, 8'h00, 0, 1, 7'd0, 1, 8'h11, 8'h00, 0};
    tbl[7] = '{0, 8'h00, 0, 0, 7'd0, 1, 8'h11, 8'h00, 0};
    #12;
    check_all();
    chk("reset_af_zero_thresh", 32'(af[0]), 32'd1);
    af_thresh = 7'd60;
    #1;
    check_all();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_count", i), 32'(cnt[0]), 32'(tbl[i].cnt));
      chk($sformatf("tbl%0d_empty", i), 32'(empty[1]), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_dout_std", i), 32'(dout[0]), 32'(tbl[i].d0));
      chk($sformatf("tbl%0d_dout_fwft", i), 32'(dout[1]), 32'(tbl[i].d1));
      chk($sformatf("tbl%0d_underflow", i), 32'(uf[0]), 32'(tbl[i].uf));
    end
    for (int i = 0; i < 64; i++) begin
      step(1, 8'(i), 0, 0);
      chk("fill_half", 32'(half[0]), 32'(i >= 31));
    end
    chk("fill_full", 32'(full[0]), 32'd1);
    chk("fill_count", 32'(cnt[0]), 32'd64);
    step(1, 8'hFF, 0, 0);
    chk("overflow_set", 32'(ov[0]), 32'd1);
    chk("overflow_count", 32'(cnt[1]), 32'd64);
    step(1, 8'h77, 1, 0);
    chk("full_rw_count", 32'(cnt[0]), 32'd63);
    chk("full_rw_dout", 32'(dout[0]), 32'h00);
    step(0, 8'h00, 0, 1);
    chk("overflow_clr", 32'(ov[1]), 32'd0);
    for (int i = 0; i < 63; i++) step(0, 8'h00, 1, 0);
    chk("drain_empty", 32'(empty[0]), 32'd1);
    step(0, 8'h00, 1, 0);
    chk("underflow_set", 32'(uf[1]), 32'd1);
    step(0, 8'h00, 1, 1);
    chk("clr_vs_set", 32'(uf[0]), 32'd1);
    step(0, 8'h00, 0, 1);
    chk("underflow_clr", 32'(uf[0]), 32'd0);
    for (int i = 0; i < 32; i++) step(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 200; i++) begin
      step(1, 8'(i), 1, 0);
      chk("stream_count", 32'(cnt[0]), 32'd32);
    end
    af_thresh = 7'd0;
    #1;
    chk("live_af", 32'(af[0]), 32'd1);
    ae_thresh = 7'd40;
    #1;
    chk("live_ae", 32'(ae[1]), 32'd1);
    check_all();
    af_thresh = 7'd60; ae_thresh = 7'd4;
    for (int i = 0; i < 15; i++) step(0, 8'h00, 1, 0);
    chk("mid_count", 32'(cnt[0]), 32'd17);
    step(1, 8'h00, 0, 0);
    step(1, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("rst_count", 32'(cnt[1]), 32'd0);
    chk("rst_dout", 32'(dout[0]), 32'd0);
    #1 rst = 1'b0;
    step(1, 8'h5A, 0, 0);
    chk("post_rst_fwft", 32'(dout[1]), 32'h5A);
    step(0, 8'h00, 1, 0);
    chk("post_rst_std", 32'(dout[0]), 32'h5A);
    for (int i = 0; i < 3000; i++) begin
      int bias = ((i / 250) % 2) ? 25 : 75;
      if ($urandom_range(0, 99) < 3) begin
        af_thresh = 7'($urandom_range(0, 70));
        ae_thresh = 7'($urandom_range(0, 70));
      end
      step($urandom_range(0, 99) < bias, 8'($urandom), $urandom_range(0, 99) >= bias - 10,
           $urandom_range(0, 99) < 5);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
